pll_lock_supervisor: RTL and testbench

Reference-clock-domain supervisor for an iCE40 PLL. Drives the PLL reset, synchronises and debounces the PLL lock flag, and releases a downstream system reset only after lock has been stable long enough. Retries on lock timeout, recovers from loss of lock, and latches a fault after repeated failures. Sits between the PLL wrapper and the signal-acquisition logic.

---
 rtl/pll_lock_supervisor.sv | 197 +++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock supervisor, running in the reference-clock domain.
// Optional build macro PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN adds an 8-bit loss-of-lock counter.
module pll_lock_supervisor #(
   parameter int SYNC_STAGES  = 2,
   parameter int RESET_PULSE  = 16,
   parameter int LOCK_TIMEOUT = 1440,
   parameter int LOCK_STABLE  = 144,
   parameter int MAX_RETRIES  = 3,
   parameter int RETRY_W      = 4
) (
   input  logic               clock_in,
   input  logic               resetb,
   input  logic               locked,
   input  logic               retry_clear,
   output logic               pll_resetb,
   output logic               sys_resetb,
   output logic               ready,
   output logic               fault,
   output logic [RETRY_W-1:0] retries,
   output logic [2:0]         state
`ifdef PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN
   ,
   output logic [7:0]         loss_count
`endif
);

   localparam int CNT_MAX = (RESET_PULSE > LOCK_TIMEOUT) ?
                            ((RESET_PULSE > LOCK_STABLE) ? RESET_PULSE : LOCK_STABLE) :
                            ((LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE);
   localparam int CNT_W = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RESET_PULSE - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

   typedef enum logic [2:0] {
      PLL_RESET = 3'd0,
      WAIT_LOCK = 3'd1,
      STABILISE = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_next;
   logic [RETRY_W-1:0]     retries_q, retries_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   pll_resetb_q, pll_resetb_d;
   logic                   run_q, run_d;
   logic                   fault_q, fault_d;
   logic                   locked_s;

   // Lock-flag synchroniser shift path; only the last stage is ever used.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], locked};
   end

   assign locked_s = sync_q[SYNC_STAGES-1];

   // Next-state, counter and retry bookkeeping.
   always_comb begin
      state_d   = state_q;
      cnt_next  = cnt_q + CNT_W'(1);
      retries_d = retries_q;
      case (state_q)
         PLL_RESET: begin
            if (cnt_q == PULSE_LAST) begin
               state_d = WAIT_LOCK;
            end else begin
               state_d = PLL_RESET;
            end
         end
         WAIT_LOCK: begin
            // Lock beats a coincident timeout.
            if (locked_s) begin
               state_d = STABILISE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               if (retries_q == RETRY_LIMIT) begin
                  state_d = FAULT;
               end else begin
                  retries_d = retries_q + RETRY_W'(1);
                  state_d   = PLL_RESET;
               end
            end else begin
               state_d = WAIT_LOCK;
            end
         end
         STABILISE: begin
            if (!locked_s) begin
               state_d = WAIT_LOCK;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = RUN;
            end else begin
               state_d = STABILISE;
            end
         end
         RUN: begin
            cnt_next = cnt_q;
            if (!locked_s) begin
               state_d = PLL_RESET;
            end else begin
               state_d = RUN;
            end
         end
         FAULT: begin
            cnt_next = cnt_q;
            if (retry_clear) begin
               state_d   = PLL_RESET;
               retries_d = '0;
            end else begin
               state_d = FAULT;
            end
         end
         default: begin
            state_d   = PLL_RESET;
            retries_d = '0;
         end
      endcase
      if (state_d != state_q) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_next;
      end
   end

   // Output decode from the next state so the registered outputs track state_q exactly.
   always_comb begin
      pll_resetb_d = 1'b1;
      run_d        = 1'b0;
      fault_d      = 1'b0;
      case (state_d)
         PLL_RESET: pll_resetb_d = 1'b0;
         WAIT_LOCK: pll_resetb_d = 1'b1;
         STABILISE: pll_resetb_d = 1'b1;
         RUN:       run_d        = 1'b1;
         FAULT: begin
            pll_resetb_d = 1'b0;
            fault_d      = 1'b1;
         end
         default:   pll_resetb_d = 1'b0;
      endcase
   end

   // State, counter, synchroniser and output registers.
   always_ff @(posedge clock_in) begin
      if (!resetb) begin
         state_q      <= PLL_RESET;
         cnt_q        <= '0;
         retries_q    <= '0;
         sync_q       <= '0;
         pll_resetb_q <= 1'b0;
         run_q        <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         retries_q    <= retries_d;
         sync_q       <= sync_d;
         pll_resetb_q <= pll_resetb_d;
         run_q        <= run_d;
         fault_q      <= fault_d;
      end
   end

   assign pll_resetb = pll_resetb_q;
   assign sys_resetb = run_q;
   assign ready      = run_q;
   assign fault      = fault_q;
   assign retries    = retries_q;
   assign state      = state_q;

`ifdef PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN
   logic [7:0] loss_q, loss_d;

   // Saturating count of lock losses seen while running; retry_clear leaves it alone.
   always_comb begin
      if ((state_q == RUN) && (state_d == PLL_RESET) && (loss_q != 8'd255)) begin
         loss_d = loss_q + 8'd1;
      end else begin
         loss_d = loss_q;
      end
   end

   // Loss counter register.
   always_ff @(posedge clock_in) begin
      if (!resetb) begin
         loss_q <= 8'd0;
      end else begin
         loss_q <= loss_d;
      end
   end

   assign loss_count = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: a per-cycle reference-model scoreboard
// plus directed measurements of pulse widths, latencies and boundary races.
module tb_pll_lock_supervisor;

   localparam int T_SS = 2;
   localparam int T_RP = 4;
   localparam int T_LT = 20;
   localparam int T_LS = 8;
   localparam int T_MR = 2;
   localparam int T_RW = 4;

   logic            clk = 1'b0;
   logic            resetb;
   logic            locked;
   logic            retry_clear;
   logic            pll_resetb;
   logic            sys_resetb;
   logic            ready;
   logic            fault;
   logic [T_RW-1:0] retries;
   logic [2:0]      state;
`ifdef PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN
   logic [7:0]      loss_count;
`endif

   int total = 0;
   int bad   = 0;

   pll_lock_supervisor #(
      .SYNC_STAGES (T_SS),
      .RESET_PULSE (T_RP),
      .LOCK_TIMEOUT(T_LT),
      .LOCK_STABLE (T_LS),
      .MAX_RETRIES (T_MR),
      .RETRY_W     (T_RW)
   ) dut (
      .clock_in   (clk),
      .resetb     (resetb),
      .locked     (locked),
      .retry_clear(retry_clear),
      .pll_resetb (pll_resetb),
      .sys_resetb (sys_resetb),
      .ready      (ready),
      .fault      (fault),
      .retries    (retries),
      .state      (state)
`ifdef PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN
      ,
      .loss_count (loss_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model of the supervisor, two-stage synchroniser.
   typedef struct {
      int st;
      int cnt;
      int ret;
      int s1;
      int s2;
      int loss;
   } mdl_t;

   function automatic mdl_t mdl_next(mdl_t c, logic lk, logic rc, logic rb);
      mdl_t n;
      int   ls;
      n = c;
      if (!rb) begin
         n = '{default: 0};
         return n;
      end
      ls    = c.s2;
      n.s1  = int'(lk);
      n.s2  = c.s1;
      n.cnt = c.cnt + 1;
      case (c.st)
         0: if (c.cnt == T_RP - 1) n.st = 1;
         1: begin
            if (ls != 0) n.st = 2;
            else if (c.cnt == T_LT - 1) begin
               if (c.ret == T_MR) n.st = 4;
               else begin
                  n.ret = c.ret + 1;
                  n.st  = 0;
               end
            end
         end
         2: begin
            if (ls == 0) n.st = 1;
            else if (c.cnt == T_LS - 1) n.st = 3;
         end
         3: begin
            if (ls == 0) begin
               n.st   = 0;
               n.loss = (c.loss < 255) ? c.loss + 1 : 255;
            end
         end
         4: begin
            if (rc) begin
               n.st  = 0;
               n.ret = 0;
            end
         end
         default: n.st = 0;
      endcase
      if (n.st != c.st) n.cnt = 0;
      return n;
   endfunction

   mdl_t mdl = '{default: 0};
   mdl_t exp_q[$];

   always @(posedge clk) begin
      mdl <= mdl_next(mdl, locked, retry_clear, resetb);
      exp_q.push_back(mdl_next(mdl, locked, retry_clear, resetb));
   end

   mdl_t e;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_val("sb_state", 32'(state), 32'(e.st));
         check_val("sb_pll_resetb", 32'(pll_resetb), (e.st != 0 && e.st != 4) ? 32'd1 : 32'd0);
         check_val("sb_sys_resetb", 32'(sys_resetb), (e.st == 3) ? 32'd1 : 32'd0);
         check_val("sb_ready", 32'(ready), (e.st == 3) ? 32'd1 : 32'd0);
         check_val("sb_fault", 32'(fault), (e.st == 4) ? 32'd1 : 32'd0);
         check_val("sb_retries", 32'(retries), 32'(e.ret));
`ifdef PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN
         check_val("sb_loss_count", 32'(loss_count), 32'(e.loss));
`endif
      end
   end

   task automatic wait_state(input int target, input int budget, input string tag);
      int n = 0;
      while (state !== 3'(target) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_val(tag, 32'(state), 32'(target));
   endtask

   task automatic count_state(input int s, input int budget, output int n);
      n = 0;
      while (state === 3'(s) && n < budget) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic count_prst_low(input int budget, output int n);
      n = 0;
      while (pll_resetb === 1'b0 && n < budget) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check_val({tag, "_state"}, 32'(state), 32'd0);
      check_val({tag, "_pll_resetb"}, 32'(pll_resetb), 32'd0);
      check_val({tag, "_sys_resetb"}, 32'(sys_resetb), 32'd0);
      check_val({tag, "_ready"}, 32'(ready), 32'd0);
      check_val({tag, "_fault"}, 32'(fault), 32'd0);
      check_val({tag, "_retries"}, 32'(retries), 32'd0);
`ifdef PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN
      check_val({tag, "_loss_count"}, 32'(loss_count), 32'd0);
`endif
   endtask

   initial begin
      int n;
      int n_stab;
      resetb      = 1'b0;
      locked      = 1'b0;
      retry_clear = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("rst");

      // Power-up: 4-cycle PLL reset, then lock and stabilise into RUN.
      resetb = 1'b1;
      count_prst_low(20, n);
      check_val("t1_prst_width", 32'(n), 32'd4);
      repeat (3) @(negedge clk);
      locked = 1'b1;
      n      = 0;
      n_stab = 0;
      while (sys_resetb !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
         if (state === 3'd2) n_stab++;
      end
      check_val("t1_lock_latency", 32'(n), 32'd11);
      check_val("t1_stab_len", 32'(n_stab), 32'd8);
      check_val("t1_ready", 32'(ready), 32'd1);
      check_val("t1_retries", 32'(retries), 32'd0);

      // Loss of lock in RUN.
      locked = 1'b0;
      n      = 0;
      while (sys_resetb !== 1'b0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check_val("t4_drop_latency", 32'(n), 32'd3);
      count_prst_low(20, n);
      check_val("t4_prst_width", 32'(n), 32'd4);
`ifdef PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN
      check_val("t4_loss_count", 32'(loss_count), 32'd1);
`endif
      locked = 1'b1;
      wait_state(3, 60, "t4_relock");
      check_val("t4_retries", 32'(retries), 32'd0);

      // Reset asserted for one cycle while running.
      resetb = 1'b0;
      @(negedge clk);
      check_reset_values("t5_run_rst");
      resetb = 1'b1;

      // One-cycle lock glitch in STABILISE, seen by the FSM at cnt=5.
      wait_state(2, 40, "t3_enter_stab");
      repeat (3) @(negedge clk);
      locked = 1'b0;
      @(negedge clk);
      locked = 1'b1;
      wait_state(1, 6, "t3_glitch_to_wait");
      check_val("t3_retries", 32'(retries), 32'd0);
      wait_state(2, 6, "t3_restab");
      count_state(2, 30, n);
      check_val("t3_full_stab", 32'(n), 32'd8);
      check_val("t3_run", 32'(state), 32'd3);

      // No lock at all: two retries then FAULT.
      locked = 1'b0;
      wait_state(1, 20, "t2_wait1");
      count_state(1, 40, n);
      check_val("t2_wait1_len", 32'(n), 32'd20);
      count_prst_low(20, n);
      check_val("t2_pulse1", 32'(n), 32'd4);
      check_val("t2_retries1", 32'(retries), 32'd1);
      retry_clear = 1'b1;
      @(negedge clk);
      retry_clear = 1'b0;
      count_state(1, 40, n);
      check_val("t2_wait2_len", 32'(n), 32'd19);
      check_val("t2_clear_ignored", 32'(retries), 32'd2);
      count_prst_low(20, n);
      check_val("t2_pulse2", 32'(n), 32'd4);
      count_state(1, 40, n);
      check_val("t2_wait3_len", 32'(n), 32'd20);
      check_val("t2_fault_state", 32'(state), 32'd4);
      check_val("t2_fault", 32'(fault), 32'd1);
      check_val("t2_fault_prst", 32'(pll_resetb), 32'd0);
      check_val("t2_fault_retries", 32'(retries), 32'd2);
      repeat (5) @(negedge clk);
      check_val("t2_fault_sticky", 32'(state), 32'd4);

      // Reset asserted for one cycle in FAULT.
      resetb = 1'b0;
      @(negedge clk);
      check_reset_values("t5_fault_rst");
      resetb = 1'b1;

      // Back into FAULT, then leave it with retry_clear.
      wait_state(4, 120, "t2_refault");
      retry_clear = 1'b1;
      @(negedge clk);
      retry_clear = 1'b0;
      check_val("t2_clear_state", 32'(state), 32'd0);
      check_val("t2_clear_retries", 32'(retries), 32'd0);
      check_val("t2_clear_fault", 32'(fault), 32'd0);
      check_val("t2_clear_prst", 32'(pll_resetb), 32'd0);

      // Lock arriving on the final timeout cycle of the last allowed attempt.
      wait_state(1, 20, "t6_w1");
      wait_state(0, 40, "t6_r1");
      wait_state(1, 20, "t6_w2");
      wait_state(0, 40, "t6_r2");
      wait_state(1, 20, "t6_w3");
      check_val("t6_pre_retries", 32'(retries), 32'd2);
      repeat (17) @(negedge clk);
      locked = 1'b1;
      n      = 0;
      while (state === 3'd1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check_val("t6_race_state", 32'(state), 32'd2);
      check_val("t6_race_retries", 32'(retries), 32'd2);
      check_val("t6_race_fault", 32'(fault), 32'd0);
      wait_state(3, 20, "t6_run");

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
